// File: rtl/adc_scan_controller.sv
// adc_scan_controller
// Scans NUM_CH channels of an ADC0804-style converter through an external
// analog mux, tagging each sample with the channel it came from. Runs one
// scan per start pulse or repeats continuously, and a per-conversion timeout
// keeps a dead converter from stalling the scan.

module adc_scan_controller #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int WR_PULSE  = 4,
    parameter int RD_CYCLES = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont_mode,
    input  logic              enable,
    input  logic              intrupt,
    input  logic [DATA_W-1:0] digital_data,
    output logic              wr_n,
    output logic              rd_n,
    output logic [CH_W-1:0]   ch_sel,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    output logic [DATA_W-1:0] led_display,
    output logic              busy,
    output logic              scan_done,
    output logic              timeout_err,
    output logic              err_sticky
);

    // One counter is shared by the write strobe, the timeout and the read strobe,
    // so it must be wide enough for the longest of the three.
    localparam int MAX_WR_RD = (WR_PULSE > RD_CYCLES) ? WR_PULSE : RD_CYCLES;
    localparam int CNT_MAX   = (TIMEOUT > MAX_WR_RD) ? TIMEOUT : MAX_WR_RD;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_EOC,
        READ,
        STORE,
        NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic                wr_n_q, wr_n_d;
    logic                rd_n_q, rd_n_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [CH_W-1:0]     data_ch_q, data_ch_d;
    logic [DATA_W-1:0]   led_q, led_d;
    logic                data_valid_q, data_valid_d;
    logic                busy_q, busy_d;
    logic                scan_done_q, scan_done_d;
    logic                timeout_err_q, timeout_err_d;
    logic                err_sticky_q, err_sticky_d;
    logic                intr_meta_q;
    logic                eoc_q;

    // Two-flop synchroniser for the asynchronous end-of-conversion input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_meta_q <= 1'b1;
            eoc_q       <= 1'b1;
        end else begin
            intr_meta_q <= intrupt;
            eoc_q       <= intr_meta_q;
        end
    end

    // Next-state and registered-output logic; every output is computed one cycle ahead
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ch_sel_d      = ch_sel_q;
        wr_n_d        = 1'b1;
        rd_n_d        = 1'b1;
        sample_d      = sample_q;
        data_out_d    = data_out_q;
        data_ch_d     = data_ch_q;
        led_d         = led_q;
        data_valid_d  = 1'b0;
        scan_done_d   = 1'b0;
        timeout_err_d = 1'b0;
        err_sticky_d  = err_sticky_q;

        unique case (state_q)
            IDLE: begin
                if (start && enable) begin
                    state_d      = START;
                    ch_sel_d     = '0;
                    err_sticky_d = 1'b0;
                    cnt_d        = '0;
                    wr_n_d       = 1'b0;
                end
            end
            START: begin
                if (cnt_q == WR_LAST) begin
                    state_d = WAIT_EOC;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    wr_n_d = 1'b0;
                end
            end
            WAIT_EOC: begin
                if (!eoc_q) begin
                    state_d = READ;
                    cnt_d   = '0;
                    rd_n_d  = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d       = NEXT;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    err_sticky_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            READ: begin
                if (cnt_q == RD_LAST) begin
                    state_d  = STORE;
                    cnt_d    = '0;
                    sample_d = digital_data;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    rd_n_d = 1'b0;
                end
            end
            STORE: begin
                state_d      = NEXT;
                data_out_d   = sample_q;
                data_ch_d    = ch_sel_q;
                led_d        = sample_q;
                data_valid_d = 1'b1;
            end
            NEXT: begin
                if (ch_sel_q == LAST_CH) begin
                    scan_done_d = 1'b1;
                    if (cont_mode && enable) begin
                        state_d  = START;
                        ch_sel_d = '0;
                        cnt_d    = '0;
                        wr_n_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (enable) begin
                    state_d  = START;
                    ch_sel_d = ch_sel_q + CH_ONE;
                    cnt_d    = '0;
                    wr_n_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously so the ADC strobes release at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ch_sel_q      <= '0;
            wr_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            sample_q      <= '0;
            data_out_q    <= '0;
            data_ch_q     <= '0;
            led_q         <= '0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            scan_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ch_sel_q      <= ch_sel_d;
            wr_n_q        <= wr_n_d;
            rd_n_q        <= rd_n_d;
            sample_q      <= sample_d;
            data_out_q    <= data_out_d;
            data_ch_q     <= data_ch_d;
            led_q         <= led_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
            scan_done_q   <= scan_done_d;
            timeout_err_q <= timeout_err_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign wr_n        = wr_n_q;
    assign rd_n        = rd_n_q;
    assign ch_sel      = ch_sel_q;
    assign data_out    = data_out_q;
    assign data_ch     = data_ch_q;
    assign data_valid  = data_valid_q;
    assign led_display = led_q;
    assign busy        = busy_q;
    assign scan_done   = scan_done_q;
    assign timeout_err = timeout_err_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_adc_scan_controller.sv
// Testbench for adc_scan_controller: a 4-channel instance (short timeout) and an
// 8-channel 10-bit instance, each with a behavioural ADC and a monitor that
// records samples, pulses and strobe widths for comparison against a scan model.
`timescale 1ns/1ps

module tb_adc_scan_controller;

    localparam int A_DW = 8,  A_NCH = 4, A_CW = 2, A_WR = 4, A_RD = 2, A_TO = 20;
    localparam int B_DW = 10, B_NCH = 8, B_CW = 3, B_WR = 3, B_RD = 3, B_TO = 40;
    localparam int LIMIT = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic              start_a = 1'b0, cont_a = 1'b0, enable_a = 1'b1, intr_a = 1'b1;
    logic [A_DW-1:0]   dig_a = '0;
    logic              wr_n_a, rd_n_a, valid_a, busy_a, done_a, to_a, sticky_a;
    logic [A_CW-1:0]   ch_sel_a, data_ch_a;
    logic [A_DW-1:0]   data_out_a, led_a;

    adc_scan_controller #(.DATA_W(A_DW), .NUM_CH(A_NCH), .CH_W(A_CW), .WR_PULSE(A_WR),
                          .RD_CYCLES(A_RD), .TIMEOUT(A_TO)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cont_mode(cont_a), .enable(enable_a),
        .intrupt(intr_a), .digital_data(dig_a), .wr_n(wr_n_a), .rd_n(rd_n_a),
        .ch_sel(ch_sel_a), .data_out(data_out_a), .data_ch(data_ch_a), .data_valid(valid_a),
        .led_display(led_a), .busy(busy_a), .scan_done(done_a), .timeout_err(to_a),
        .err_sticky(sticky_a));

    // ---------------- instance B ----------------
    logic              start_b = 1'b0, cont_b = 1'b0, enable_b = 1'b1, intr_b = 1'b1;
    logic [B_DW-1:0]   dig_b = '0;
    logic              wr_n_b, rd_n_b, valid_b, busy_b, done_b, to_b, sticky_b;
    logic [B_CW-1:0]   ch_sel_b, data_ch_b;
    logic [B_DW-1:0]   data_out_b, led_b;

    adc_scan_controller #(.DATA_W(B_DW), .NUM_CH(B_NCH), .CH_W(B_CW), .WR_PULSE(B_WR),
                          .RD_CYCLES(B_RD), .TIMEOUT(B_TO)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cont_mode(cont_b), .enable(enable_b),
        .intrupt(intr_b), .digital_data(dig_b), .wr_n(wr_n_b), .rd_n(rd_n_b),
        .ch_sel(ch_sel_b), .data_out(data_out_b), .data_ch(data_ch_b), .data_valid(valid_b),
        .led_display(led_b), .busy(busy_b), .scan_done(done_b), .timeout_err(to_b),
        .err_sticky(sticky_b));

    // Per-channel analog values seen through the mux, and dead-channel flags
    logic [A_DW-1:0] adc_val_a [A_NCH];
    logic [B_DW-1:0] adc_val_b [B_NCH];
    bit              dead_a    [A_NCH];

    // Model state and monitor records
    int cd_a = -1, cd_b = -1, fall_cyc_a = 0, fall_cyc_b = 0;
    logic wr_prev_a = 1'b1, rd_prev_a = 1'b1, wr_prev_b = 1'b1, rd_prev_b = 1'b1;
    int obs_a[$], valid_cyc_a[$], lat_a[$], done_cyc_a[$], to_cyc_a[$];
    int wr_len_a[$], wr_rise_a[$], wr_fall_a[$], rd_len_a[$];
    int obs_b[$], lat_b[$], done_cyc_b[$], wr_len_b[$];
    int wr_run_a = 0, rd_run_a = 0, wr_run_b = 0;
    bit led_bad_a = 1'b0;
    int exp_a[$], exp_b[$];
    int exp_scans_a = 0, exp_scans_b = 0;

    // Behavioural ADC A: converts after a random delay once wr_n rises, releases on rd_n rise
    always @(negedge clk) begin
        if (!rst_n) begin
            intr_a = 1'b1;
            cd_a   = -1;
        end else begin
            if (wr_n_a && !wr_prev_a && !dead_a[ch_sel_a]) begin
                cd_a = $urandom_range(1, 14);
            end else if (cd_a > 0) begin
                cd_a--;
                if (cd_a == 0) begin
                    intr_a     = 1'b0;
                    dig_a      = adc_val_a[ch_sel_a];
                    fall_cyc_a = cyc;
                    cd_a       = -1;
                end
            end
            if (rd_n_a && !rd_prev_a) intr_a = 1'b1;
        end
        wr_prev_a = wr_n_a;
        rd_prev_a = rd_n_a;
    end

    // Behavioural ADC B
    always @(negedge clk) begin
        if (!rst_n) begin
            intr_b = 1'b1;
            cd_b   = -1;
        end else begin
            if (wr_n_b && !wr_prev_b) begin
                cd_b = $urandom_range(1, 30);
            end else if (cd_b > 0) begin
                cd_b--;
                if (cd_b == 0) begin
                    intr_b     = 1'b0;
                    dig_b      = adc_val_b[ch_sel_b];
                    fall_cyc_b = cyc;
                    cd_b       = -1;
                end
            end
            if (rd_n_b && !rd_prev_b) intr_b = 1'b1;
        end
        wr_prev_b = wr_n_b;
        rd_prev_b = rd_n_b;
    end

    // Monitor A: records samples, pulse times and strobe widths away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a) begin
                obs_a.push_back((int'(data_ch_a) << 16) | int'(data_out_a));
                valid_cyc_a.push_back(cyc);
                lat_a.push_back(cyc - fall_cyc_a);
                if (led_a !== data_out_a) led_bad_a = 1'b1;
            end
            if (done_a) done_cyc_a.push_back(cyc);
            if (to_a) to_cyc_a.push_back(cyc);
            if (!wr_n_a) begin
                if (wr_run_a == 0) wr_fall_a.push_back(cyc);
                wr_run_a++;
            end else if (wr_run_a > 0) begin
                wr_len_a.push_back(wr_run_a);
                wr_rise_a.push_back(cyc);
                wr_run_a = 0;
            end
            if (!rd_n_a) rd_run_a++;
            else if (rd_run_a > 0) begin
                rd_len_a.push_back(rd_run_a);
                rd_run_a = 0;
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_b) begin
                obs_b.push_back((int'(data_ch_b) << 16) | int'(data_out_b));
                lat_b.push_back(cyc - fall_cyc_b);
            end
            if (done_b) done_cyc_b.push_back(cyc);
            if (!wr_n_b) wr_run_b++;
            else if (wr_run_b > 0) begin
                wr_len_b.push_back(wr_run_b);
                wr_run_b = 0;
            end
        end
    end

    // Scan model: channels are visited in order; dead channels yield no sample
    function automatic void model_a(input int visits);
        exp_a.delete();
        for (int v = 0; v < visits; v++) begin
            int ch;
            ch = v % A_NCH;
            if (!dead_a[ch]) exp_a.push_back((ch << 16) | int'(adc_val_a[ch]));
        end
        exp_scans_a = visits / A_NCH;
    endfunction

    function automatic void model_b(input int visits);
        exp_b.delete();
        for (int v = 0; v < visits; v++) begin
            exp_b.push_back(((v % B_NCH) << 16) | int'(adc_val_b[v % B_NCH]));
        end
        exp_scans_b = visits / B_NCH;
    endfunction

    task automatic clear_mon();
        obs_a.delete(); valid_cyc_a.delete(); lat_a.delete(); done_cyc_a.delete();
        to_cyc_a.delete(); wr_len_a.delete(); wr_rise_a.delete(); wr_fall_a.delete();
        rd_len_a.delete(); obs_b.delete(); lat_b.delete(); done_cyc_b.delete();
        wr_len_b.delete();
        wr_run_a = 0; rd_run_a = 0; wr_run_b = 0; led_bad_a = 1'b0;
    endtask

    task automatic pulse_start(input bit sel_b, output int at_cyc);
        @(negedge clk);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        at_cyc = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel_b, input string name);
        int n = 0;
        while ((sel_b ? busy_b : busy_a) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sel_b ? busy_b : busy_a) begin
            failures++;
            $display("[TB] FAIL %s_idle_wait: busy still 1 after %0d cycles, required 0", name, LIMIT);
        end
    endtask

    task automatic wait_samples(input bit sel_b, input int count, input string name);
        int n = 0;
        while ((sel_b ? obs_b.size() : obs_a.size()) < count && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((sel_b ? obs_b.size() : obs_a.size()) < count) begin
            failures++;
            $display("[TB] FAIL %s_sample_wait: got %0d samples, required %0d", name,
                     sel_b ? obs_b.size() : obs_a.size(), count);
        end
    endtask

    task automatic test_reset();
        logic [26:0] got_a;
        logic [32:0] got_b;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got_a = {wr_n_a, rd_n_a, ch_sel_a, data_out_a, data_ch_a, led_a, valid_a, busy_a, done_a, to_a, sticky_a};
        got_b = {wr_n_b, rd_n_b, ch_sel_b, data_out_b, data_ch_b, led_b, valid_b, busy_b, done_b, to_b, sticky_b};
        checks++;
        if (got_a !== {2'b11, 25'd0}) begin
            failures++;
            $display("[TB] FAIL reset_a_outputs: got %h required %h", got_a, {2'b11, 25'd0});
        end
        checks++;
        if (got_b !== {2'b11, 31'd0}) begin
            failures++;
            $display("[TB] FAIL reset_b_outputs: got %h required %h", got_b, {2'b11, 31'd0});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || wr_n_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_idle: busy=%b wr_n=%b, required busy=0 wr_n=1", busy_a, wr_n_a);
        end
    endtask

    task automatic test_single_scan(input bit fixed, input string name);
        int st;
        for (int c = 0; c < A_NCH; c++) begin
            adc_val_a[c] = fixed ? A_DW'(8'h6C + c) : A_DW'($urandom);
            dead_a[c]    = 1'b0;
        end
        clear_mon();
        model_a(A_NCH);
        pulse_start(1'b0, st);
        wait_idle(1'b0, name);
        checks++;
        if (obs_a.size() != exp_a.size()) begin
            failures++;
            $display("[TB] FAIL %s_count: got %0d samples, required %0d", name, obs_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin
                failures++;
                $display("[TB] FAIL %s_sample%0d: got %h required %h", name, i,
                         (i < obs_a.size()) ? obs_a[i] : -1, exp_a[i]);
            end
        end
        checks++;
        if (done_cyc_a.size() != exp_scans_a || valid_cyc_a.size() == 0 ||
            done_cyc_a[0] != valid_cyc_a[valid_cyc_a.size()-1] + 1) begin
            failures++;
            $display("[TB] FAIL %s_scan_done: got %0d pulses, required %0d one cycle after last sample",
                     name, done_cyc_a.size(), exp_scans_a);
        end
        checks++;
        if (wr_len_a.size() != A_NCH || rd_len_a.size() != A_NCH) begin
            failures++;
            $display("[TB] FAIL %s_strobe_count: got wr=%0d rd=%0d, required %0d each", name,
                     wr_len_a.size(), rd_len_a.size(), A_NCH);
        end
        for (int i = 0; i < wr_len_a.size(); i++) begin
            checks++;
            if (wr_len_a[i] != A_WR) begin
                failures++;
                $display("[TB] FAIL %s_wr_width%0d: got %0d required %0d", name, i, wr_len_a[i], A_WR);
            end
        end
        for (int i = 0; i < rd_len_a.size(); i++) begin
            checks++;
            if (rd_len_a[i] != A_RD) begin
                failures++;
                $display("[TB] FAIL %s_rd_width%0d: got %0d required %0d", name, i, rd_len_a[i], A_RD);
            end
        end
        for (int i = 0; i < lat_a.size(); i++) begin
            checks++;
            if (lat_a[i] != 2 + 1 + A_RD + 1) begin
                failures++;
                $display("[TB] FAIL %s_latency%0d: got %0d required %0d", name, i, lat_a[i], 2 + 1 + A_RD + 1);
            end
        end
        checks++;
        if (wr_fall_a.size() == 0 || wr_fall_a[0] - st != 1) begin
            failures++;
            $display("[TB] FAIL %s_start_to_wr: got %0d cycles, required 1", name,
                     (wr_fall_a.size() > 0) ? wr_fall_a[0] - st : -1);
        end
        checks++;
        if (led_bad_a || led_a !== adc_val_a[A_NCH-1]) begin
            failures++;
            $display("[TB] FAIL %s_led: got %h required %h", name, led_a, adc_val_a[A_NCH-1]);
        end
        checks++;
        if (to_cyc_a.size() != 0 || sticky_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_no_error: got timeouts=%0d sticky=%b, required 0 and 0", name,
                     to_cyc_a.size(), sticky_a);
        end
    endtask

    task automatic test_start_while_busy();
        int st, st2;
        for (int c = 0; c < A_NCH; c++) adc_val_a[c] = A_DW'($urandom);
        clear_mon();
        model_a(A_NCH);
        pulse_start(1'b0, st);
        repeat (25) @(negedge clk);
        pulse_start(1'b0, st2);
        wait_idle(1'b0, "busy_start");
        checks++;
        if (obs_a.size() != exp_a.size() || done_cyc_a.size() != 1 || wr_len_a.size() != A_NCH) begin
            failures++;
            $display("[TB] FAIL busy_start_count: got samples=%0d done=%0d strobes=%0d, required %0d 1 %0d",
                     obs_a.size(), done_cyc_a.size(), wr_len_a.size(), exp_a.size(), A_NCH);
        end
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i]) begin
                failures++;
                $display("[TB] FAIL busy_start_sample%0d: got %h required %h", i, obs_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int st;
        for (int c = 0; c < A_NCH; c++) begin
            adc_val_a[c] = A_DW'($urandom);
            dead_a[c]    = (c == 2);
        end
        clear_mon();
        model_a(A_NCH);
        pulse_start(1'b0, st);
        wait_idle(1'b0, "timeout");
        checks++;
        if (obs_a.size() != exp_a.size()) begin
            failures++;
            $display("[TB] FAIL timeout_count: got %0d samples, required %0d", obs_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i]) begin
                failures++;
                $display("[TB] FAIL timeout_sample%0d: got %h required %h", i, obs_a[i], exp_a[i]);
            end
        end
        checks++;
        if (to_cyc_a.size() != 1 || wr_rise_a.size() < 3 || to_cyc_a[0] - wr_rise_a[2] != A_TO) begin
            failures++;
            $display("[TB] FAIL timeout_pulse: got %0d pulses, required 1 pulse %0d cycles into WAIT_EOC",
                     to_cyc_a.size(), A_TO);
        end
        checks++;
        if (done_cyc_a.size() != 1) begin
            failures++;
            $display("[TB] FAIL timeout_scan_done: got %0d required 1", done_cyc_a.size());
        end
        repeat (5) @(negedge clk);
        checks++;
        if (sticky_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_sticky_set: got %b required 1", sticky_a);
        end
        dead_a[2] = 1'b0;
        clear_mon();
        model_a(A_NCH);
        pulse_start(1'b0, st);
        checks++;
        if (sticky_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_sticky_clear: got %b required 0", sticky_a);
        end
        wait_idle(1'b0, "timeout_recover");
        checks++;
        if (obs_a.size() != A_NCH || sticky_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_recover: got samples=%0d sticky=%b, required %0d and 0",
                     obs_a.size(), sticky_a, A_NCH);
        end
    endtask

    task automatic test_continuous();
        int st;
        for (int c = 0; c < A_NCH; c++) adc_val_a[c] = A_DW'($urandom);
        cont_a = 1'b1;
        clear_mon();
        model_a(A_NCH + 2);
        pulse_start(1'b0, st);
        wait_samples(1'b0, A_NCH + 1, "continuous");
        repeat (3) @(negedge clk);
        enable_a = 1'b0;
        wait_idle(1'b0, "continuous");
        checks++;
        if (obs_a.size() != exp_a.size()) begin
            failures++;
            $display("[TB] FAIL continuous_count: got %0d samples, required %0d", obs_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i]) begin
                failures++;
                $display("[TB] FAIL continuous_sample%0d: got %h required %h", i, obs_a[i], exp_a[i]);
            end
        end
        checks++;
        if (done_cyc_a.size() != exp_scans_a || valid_cyc_a.size() < A_NCH ||
            done_cyc_a[0] != valid_cyc_a[A_NCH-1] + 1) begin
            failures++;
            $display("[TB] FAIL continuous_scan_done: got %0d pulses, required %0d after first scan",
                     done_cyc_a.size(), exp_scans_a);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL continuous_busy: got %b required 0", busy_a);
        end
        cont_a   = 1'b0;
        enable_a = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        int st, n;
        for (int c = 0; c < A_NCH; c++) adc_val_a[c] = A_DW'($urandom) | A_DW'(1);
        clear_mon();
        pulse_start(1'b0, st);
        n = 0;
        while (!(rd_len_a.size() >= 1 && !rd_n_a) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (led_a !== adc_val_a[0] || rd_n_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midread_setup: got led=%h rd_n=%b, required led=%h rd_n=0",
                     led_a, rd_n_a, adc_val_a[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_n_a !== 1'b1 || busy_a !== 1'b0 || led_a !== '0 || wr_n_a !== 1'b1 || ch_sel_a !== '0) begin
            failures++;
            $display("[TB] FAIL midread_async_reset: got rd_n=%b busy=%b led=%h wr_n=%b ch_sel=%0d, required 1 0 00 1 0",
                     rd_n_a, busy_a, led_a, wr_n_a, ch_sel_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        model_a(A_NCH);
        pulse_start(1'b0, st);
        wait_idle(1'b0, "midread_restart");
        checks++;
        if (obs_a.size() != exp_a.size() || done_cyc_a.size() != 1) begin
            failures++;
            $display("[TB] FAIL midread_restart_count: got samples=%0d done=%0d, required %0d and 1",
                     obs_a.size(), done_cyc_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i]) begin
                failures++;
                $display("[TB] FAIL midread_restart_sample%0d: got %h required %h", i, obs_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_param_sweep();
        int st;
        for (int c = 0; c < B_NCH; c++) adc_val_b[c] = B_DW'($urandom) | B_DW'(10'h200);
        cont_b = 1'b1;
        clear_mon();
        model_b(B_NCH + 2);
        pulse_start(1'b1, st);
        wait_samples(1'b1, B_NCH + 1, "sweep");
        repeat (3) @(negedge clk);
        enable_b = 1'b0;
        wait_idle(1'b1, "sweep");
        checks++;
        if (obs_b.size() != exp_b.size() || done_cyc_b.size() != exp_scans_b) begin
            failures++;
            $display("[TB] FAIL sweep_count: got samples=%0d done=%0d, required %0d and %0d",
                     obs_b.size(), done_cyc_b.size(), exp_b.size(), exp_scans_b);
        end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            checks++;
            if (obs_b[i] !== exp_b[i]) begin
                failures++;
                $display("[TB] FAIL sweep_sample%0d: got %h required %h", i, obs_b[i], exp_b[i]);
            end
        end
        for (int i = 0; i < lat_b.size(); i++) begin
            checks++;
            if (lat_b[i] != 2 + 1 + B_RD + 1 || wr_len_b[i] != B_WR) begin
                failures++;
                $display("[TB] FAIL sweep_timing%0d: got latency=%0d wr_width=%0d, required %0d and %0d",
                         i, lat_b[i], wr_len_b[i], 2 + 1 + B_RD + 1, B_WR);
            end
        end
        checks++;
        if (busy_b !== 1'b0 || led_b !== adc_val_b[1]) begin
            failures++;
            $display("[TB] FAIL sweep_final: got busy=%b led=%h, required 0 and %h", busy_b, led_b, adc_val_b[1]);
        end
        cont_b   = 1'b0;
        enable_b = 1'b1;
    endtask

    // Runs every scenario in sequence and prints the summary
    initial begin
        test_reset();
        test_single_scan(1'b1, "scan_fixed");
        for (int r = 0; r < 3; r++) test_single_scan(1'b0, "scan_random");
        test_start_while_busy();
        test_timeout();
        test_continuous();
        test_reset_mid_read();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit in case a scenario stalls outside its own bounds
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
